// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types for the integer write-back path: register address, write-back entry
// and the write-port source select.
package orv32_wb_pkg;

  localparam int WB_WIDTH    = 32;
  localparam int WB_DEPTH    = 32;
  localparam int WB_DEPTHMSB = $clog2(WB_DEPTH) - 1;

  typedef logic [WB_DEPTHMSB:0] regaddr_t;
  typedef logic [WB_WIDTH-1:0]  regdata_t;

  localparam regaddr_t REG_ZERO = '0;

  typedef struct packed {
    regaddr_t rd;
    regdata_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_ALU  = 2'd3
  } wb_src_t;

  function automatic logic is_reg_zero(input regaddr_t a);
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of ALU, load, decode and register-file signals around the write-back controller.
// slave = controller view, master = environment view.
interface regfile_wb_ctrl_if #(
  parameter int WIDTH    = 32,
  parameter int DEPTHMSB = 4
);

  logic                     alu_valid;
  logic                     alu_ready;
  logic [DEPTHMSB:0]        alu_rd;
  logic [WIDTH-1:0]         alu_data;
  logic                     ld_issue_valid;
  logic [DEPTHMSB:0]        ld_issue_rd;
  logic                     ld_ret_valid;
  logic [DEPTHMSB:0]        ld_ret_rd;
  logic [WIDTH-1:0]         ld_ret_data;
  logic [1:0][DEPTHMSB:0]   dec_ra;
  logic [1:0]               dec_busy;
  logic [1:0]               dec_byp_valid;
  logic [1:0][WIDTH-1:0]    dec_byp_data;
  logic                     rf_we;
  logic [DEPTHMSB:0]        rf_wa;
  logic [WIDTH-1:0]         rf_wd;
  logic                     rf_wb_en;
  logic                     err;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_issue_rd,
    input  ld_ret_valid, ld_ret_rd, ld_ret_data,
    input  dec_ra,
    output alu_ready, dec_busy, dec_byp_valid, dec_byp_data,
    output rf_we, rf_wa, rf_wd, rf_wb_en, err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_issue_rd,
    output ld_ret_valid, ld_ret_rd, ld_ret_data,
    output dec_ra,
    input  alu_ready, dec_busy, dec_byp_valid, dec_byp_data,
    input  rf_we, rf_wa, rf_wd, rf_wb_en, err
  );

endinterface

// File: rtl/regfile_wb_ctrl_skid_fifo.sv
// Small skid FIFO holding ALU results that lost write-port arbitration; 0-cycle read of head.
// Push while full is dropped unless a pop frees the slot in the same cycle; head/tail exposed for bypass.
module wb_skid_fifo
  import orv32_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       push_entry,
  output wb_entry_t       head,
  output wb_entry_t       tail,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  wb_entry_t       mem_q [FIFO_DEPTH];
  wb_entry_t       mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   tail_idx;
  logic            do_push;
  logic            do_pop;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign tail_idx = wr_ptr_q - PW'(1);
  assign head     = mem_q[rd_ptr_q];
  assign tail     = mem_q[tail_idx];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: merges load returns and ALU results onto the single RF write port, 1-cycle latency.
// Loads are never stalled; ALU backpressure via alu_ready = skid FIFO not full (ignores same-cycle pop).
module regfile_wb_ctrl
  import orv32_wb_pkg::*;
#(
  parameter int WIDTH      = WB_WIDTH,
  parameter int DEPTH      = WB_DEPTH,
  parameter int DEPTHMSB   = $clog2(DEPTH) - 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_ctrl_if.slave    bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 alu_hs;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  wb_entry_t            fifo_head;
  wb_entry_t            fifo_tail;
  wb_entry_t            alu_entry;
  wb_entry_t            ld_entry;
  wb_entry_t            win;
  wb_src_t              src;

  logic                 rf_we_q, rf_we_d;
  logic [DEPTHMSB:0]    rf_wa_q, rf_wa_d;
  logic [WIDTH-1:0]     rf_wd_q, rf_wd_d;
  logic [DEPTH-1:0]     sb_q, sb_d;
  logic                 err_q, err_d;

  logic [1:0]               byp_valid;
  logic [1:0][WIDTH-1:0]    byp_data;
  logic [1:0]               busy;

  assign bus.alu_ready = ~rst & (fifo_count < CW'(FIFO_DEPTH));
  assign alu_hs        = bus.alu_valid & bus.alu_ready;
  assign alu_entry     = '{rd: bus.alu_rd, data: bus.alu_data};
  assign ld_entry      = '{rd: bus.ld_ret_rd, data: bus.ld_ret_data};

  wb_skid_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_entry (alu_entry),
    .head       (fifo_head),
    .tail       (fifo_tail),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Load returns cannot stall, so they always win; queued ALU results keep program order ahead of new ones.
  always_comb begin
    src       = SRC_NONE;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    win       = '0;
    rf_we_d   = 1'b0;
    rf_wa_d   = rf_wa_q;
    rf_wd_d   = rf_wd_q;
    if (bus.ld_ret_valid) begin
      src = SRC_LD;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end else if (alu_hs) begin
      src = SRC_ALU;
    end
    fifo_pop  = (src == SRC_FIFO);
    fifo_push = alu_hs & (src != SRC_ALU);
    case (src)
      SRC_LD:   win = ld_entry;
      SRC_FIFO: win = fifo_head;
      SRC_ALU:  win = alu_entry;
      default:  win = '0;
    endcase
    if (src != SRC_NONE && !is_reg_zero(win.rd)) begin
      rf_we_d = 1'b1;
      rf_wa_d = win.rd;
      rf_wd_d = win.data;
    end
  end

  // Clear before set so an issue and return to the same rd in one cycle leaves it pending.
  always_comb begin
    sb_d = sb_q;
    if (bus.ld_ret_valid) begin
      sb_d[bus.ld_ret_rd] = 1'b0;
    end
    if (bus.ld_issue_valid && !is_reg_zero(bus.ld_issue_rd)) begin
      sb_d[bus.ld_issue_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (bus.ld_ret_valid && !is_reg_zero(bus.ld_ret_rd) && !sb_q[bus.ld_ret_rd]) begin
      err_d = 1'b1;
    end
    if (alu_hs && sb_q[bus.alu_rd]) begin
      err_d = 1'b1;
    end
    if (fifo_push && fifo_full) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    byp_valid = '0;
    byp_data  = '0;
    busy      = '0;
    for (int p = 0; p < 2; p++) begin
      if (!is_reg_zero(bus.dec_ra[p])) begin
        if (!fifo_empty && fifo_tail.rd == bus.dec_ra[p]) begin
          byp_valid[p] = 1'b1;
          byp_data[p]  = fifo_tail.data;
        end else if (!fifo_empty && fifo_head.rd == bus.dec_ra[p]) begin
          byp_valid[p] = 1'b1;
          byp_data[p]  = fifo_head.data;
        end else if (rf_we_q && rf_wa_q == bus.dec_ra[p]) begin
          byp_valid[p] = 1'b1;
          byp_data[p]  = rf_wd_q;
        end
        busy[p] = sb_q[bus.dec_ra[p]] & ~byp_valid[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      sb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      sb_q    <= sb_d;
      err_q   <= err_d;
    end
  end

  assign bus.rf_we         = rf_we_q;
  assign bus.rf_wa         = rf_wa_q;
  assign bus.rf_wd         = rf_wd_q;
  assign bus.rf_wb_en      = rf_we_q;
  assign bus.err           = err_q;
  assign bus.dec_busy      = busy;
  assign bus.dec_byp_valid = byp_valid;
  assign bus.dec_byp_data  = byp_data;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: arbitration, skid backpressure, scoreboard, bypass, x0, errors, reset.
module tb_regfile_wb_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  logic hs;

  regfile_wb_ctrl_if #(.WIDTH(32), .DEPTHMSB(4)) bus ();

  regfile_wb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid      = 1'b0;
    bus.alu_rd         = '0;
    bus.alu_data       = '0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_rd    = '0;
    bus.ld_ret_valid   = 1'b0;
    bus.ld_ret_rd      = '0;
    bus.ld_ret_data    = '0;
    bus.dec_ra         = '0;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    idle();
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = rd;
    tick();
    idle();
  endtask

  initial begin
    logic [4:0]  exp_wa [8];
    logic [31:0] exp_wd [8];
    int k;
    int nw;

    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b1;
    idle();
    repeat (3) tick();
    check_eq("rst_we", bus.rf_we, 0);
    check_eq("rst_wa", bus.rf_wa, 0);
    check_eq("rst_wd", bus.rf_wd, 0);
    check_eq("rst_wb_en", bus.rf_wb_en, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_ready", bus.alu_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", bus.alu_ready, 1);

    // single ALU result, bypass from output register
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    tick();
    idle(); bus.dec_ra[0] = 5'd5; #1;
    check_eq("alu_we", bus.rf_we, 1);
    check_eq("alu_wa", bus.rf_wa, 5);
    check_eq("alu_wd", bus.rf_wd, 32'h1234);
    check_eq("alu_wb_en", bus.rf_wb_en, 1);
    check_eq("alu_byp_v", bus.dec_byp_valid[0], 1);
    check_eq("alu_byp_d", bus.dec_byp_data[0], 32'h1234);
    check_eq("alu_busy", bus.dec_busy[0], 0);
    tick();
    check_eq("alu_we_off", bus.rf_we, 0);

    // load return and ALU in the same cycle
    issue_load(5'd7);
    bus.dec_ra[0] = 5'd7; #1;
    check_eq("cf_busy7", bus.dec_busy[0], 1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA;
    bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'd7; bus.ld_ret_data = 32'hB;
    tick();
    idle(); bus.dec_ra[0] = 5'd7; bus.dec_ra[1] = 5'd3; #1;
    check_eq("cf1_we", bus.rf_we, 1);
    check_eq("cf1_wa", bus.rf_wa, 7);
    check_eq("cf1_wd", bus.rf_wd, 32'hB);
    check_eq("cf1_byp7_d", bus.dec_byp_data[0], 32'hB);
    check_eq("cf1_busy7", bus.dec_busy[0], 0);
    check_eq("cf1_byp3_v", bus.dec_byp_valid[1], 1);
    check_eq("cf1_byp3_d", bus.dec_byp_data[1], 32'hA);
    tick();
    bus.dec_ra[1] = 5'd3; #1;
    check_eq("cf2_wa", bus.rf_wa, 3);
    check_eq("cf2_wd", bus.rf_wd, 32'hA);
    check_eq("cf2_byp3_v", bus.dec_byp_valid[1], 1);
    tick();
    bus.dec_ra[1] = 5'd3; #1;
    check_eq("cf3_we", bus.rf_we, 0);
    check_eq("cf3_byp3_v", bus.dec_byp_valid[1], 0);
    check_eq("cf3_ready", bus.alu_ready, 1);

    // four back-to-back load returns while ALU streams four results
    for (int i = 0; i < 4; i++) issue_load(5'(10 + i));
    for (int i = 0; i < 4; i++) begin
      exp_wa[i]     = 5'(10 + i);
      exp_wd[i]     = 32'h100 + 32'(i);
      exp_wa[i + 4] = 5'(20 + i);
      exp_wd[i + 4] = 32'h200 + 32'(i);
    end
    k  = 0;
    nw = 0;
    for (int c = 0; c < 14; c++) begin
      idle();
      if (c < 4) begin
        bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'(10 + c); bus.ld_ret_data = 32'h100 + 32'(c);
      end
      if (k < 4) begin
        bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + k); bus.alu_data = 32'h200 + 32'(k);
      end
      #1;
      if (c < 4) check_eq($sformatf("bp_ready_c%0d", c), bus.alu_ready, (c < 2) ? 1 : 0);
      hs = bus.alu_valid & bus.alu_ready;
      tick();
      if (hs) k++;
      if (bus.rf_we) begin
        if (nw < 8) begin
          check_eq($sformatf("bp_wa%0d", nw), bus.rf_wa, exp_wa[nw]);
          check_eq($sformatf("bp_wd%0d", nw), bus.rf_wd, exp_wd[nw]);
        end
        nw++;
      end
    end
    idle();
    check_eq("bp_nwrites", nw, 8);
    check_eq("bp_accepts", k, 4);

    // scoreboard busy window for x9
    issue_load(5'd9);
    bus.dec_ra[0] = 5'd9; #1;
    check_eq("sb_busy_a", bus.dec_busy[0], 1);
    tick();
    bus.dec_ra[0] = 5'd9; #1;
    check_eq("sb_busy_b", bus.dec_busy[0], 1);
    bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'd9; bus.ld_ret_data = 32'h99; #1;
    check_eq("sb_busy_ret", bus.dec_busy[0], 1);
    tick();
    idle(); bus.dec_ra[0] = 5'd9; #1;
    check_eq("sb_busy_r1", bus.dec_busy[0], 0);
    check_eq("sb_byp_v_r1", bus.dec_byp_valid[0], 1);
    check_eq("sb_byp_d_r1", bus.dec_byp_data[0], 32'h99);
    check_eq("sb_wa_r1", bus.rf_wa, 9);
    tick();
    bus.dec_ra[0] = 5'd9; #1;
    check_eq("sb_busy_r2", bus.dec_busy[0], 0);
    check_eq("sb_byp_v_r2", bus.dec_byp_valid[0], 0);

    // same-cycle issue and return to x9 leaves it pending
    issue_load(5'd9);
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
    bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'd9; bus.ld_ret_data = 32'h55;
    tick();
    idle(); bus.dec_ra[0] = 5'd9; #1;
    check_eq("sc_byp_d", bus.dec_byp_data[0], 32'h55);
    check_eq("sc_busy_byp", bus.dec_busy[0], 0);
    tick();
    bus.dec_ra[0] = 5'd9; #1;
    check_eq("sc_busy_set", bus.dec_busy[0], 1);
    bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'd9; bus.ld_ret_data = 32'h66;
    tick();
    idle(); tick();
    bus.dec_ra[0] = 5'd9; #1;
    check_eq("sc_busy_clr", bus.dec_busy[0], 0);
    check_eq("sc_err", bus.err, 0);

    // x0 destination is accepted but never written
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF; #1;
    check_eq("x0_ready", bus.alu_ready, 1);
    tick();
    idle(); #1;
    check_eq("x0_we", bus.rf_we, 0);
    check_eq("x0_busy", bus.dec_busy[0], 0);
    check_eq("x0_byp_v", bus.dec_byp_valid[0], 0);
    tick();
    check_eq("x0_we_late", bus.rf_we, 0);

    // return with no pending load is a sticky error
    bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'd4; bus.ld_ret_data = 32'h4444;
    tick();
    idle(); #1;
    check_eq("err_set", bus.err, 1);
    tick();
    check_eq("err_hold", bus.err, 1);

    // reset while FIFO holds two entries
    issue_load(5'd14);
    issue_load(5'd15);
    bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'd14; bus.ld_ret_data = 32'hE;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd21; bus.alu_data = 32'h21;
    tick();
    idle();
    bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 5'd15; bus.ld_ret_data = 32'hF;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd22; bus.alu_data = 32'h22; #1;
    check_eq("mid_ready1", bus.alu_ready, 1);
    tick();
    idle(); #1;
    check_eq("mid_full_ready", bus.alu_ready, 0);
    rst = 1'b1; #1;
    check_eq("mid_rst_ready", bus.alu_ready, 0);
    tick();
    check_eq("mid_rst_we", bus.rf_we, 0);
    check_eq("mid_rst_err", bus.err, 0);
    check_eq("mid_rst_ready2", bus.alu_ready, 0);
    rst = 1'b0; #1;
    check_eq("mid_post_ready", bus.alu_ready, 1);
    tick();
    bus.dec_ra[0] = 5'd21; #1;
    check_eq("mid_post_we", bus.rf_we, 0);
    check_eq("mid_post_byp", bus.dec_byp_valid[0], 0);

    // ALU write to a register with a load outstanding
    issue_load(5'd6);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h1;
    tick();
    idle(); #1;
    check_eq("waw_err", bus.err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller directly upstream of the integer register file.
- Merges ALU results and load returns onto the register file's single write port, using a small skid FIFO and a load-pending scoreboard.
- Provides read-hazard busy flags and bypass data to decode for its two read addresses.
- Drives the register file's we/wa/wd and write-back-enable inputs from registered outputs.

Parameters:
- WIDTH, 32, data width of a register
- DEPTH, 32, number of architectural registers (x0 hardwired zero)
- DEPTHMSB, $clog2(DEPTH)-1, MSB of a register address
- FIFO_DEPTH, 2, ALU skid FIFO entries (power of two, >=2)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  FIFO can accept; handshake = alu_valid & alu_ready
- alu_rd  in  DEPTHMSB+1  ALU destination
- alu_data  in  WIDTH  ALU result
- ld_issue_valid  in  1  load issued this cycle
- ld_issue_rd  in  DEPTHMSB+1  load destination
- ld_ret_valid  in  1  load data returned (cannot be stalled)
- ld_ret_rd  in  DEPTHMSB+1  returning load destination
- ld_ret_data  in  WIDTH  load data
- dec_ra  in  2x(DEPTHMSB+1)  decode read addresses
- dec_busy  out  2  per port: operand not yet available
- dec_byp_valid  out  2  per port: bypass data valid
- dec_byp_data  out  2xWIDTH  per port bypass value
- rf_we  out  1  register file write enable
- rf_wa  out  DEPTHMSB+1  register file write address
- rf_wd  out  WIDTH  register file write data
- rf_wb_en  out  1  register file write-back enable (equals rf_we)
- err  out  1  sticky protocol error

Behaviour:
- Reset: rf_we=0, rf_wa=0, rf_wd=0, rf_wb_en=0; FIFO empty; scoreboard all 0; err=0; alu_ready=0 while rst is high, 1 the cycle after.
- Output register arbitration, per cycle, priority order:
  - ld_ret_valid: take the load return.
  - else FIFO non-empty: pop head.
  - else alu handshake: take ALU directly, FIFO untouched.
  - else rf_we=0 next cycle.
- Latency: a source selected in cycle N appears on rf_we/wa/wd in cycle N+1. The register file commits it at the end of N+1.
- Enqueue: an accepted ALU result is enqueued when a load return is present or the FIFO is non-empty. Push and pop in the same cycle are legal; count stays unchanged.
- alu_ready = (count < FIFO_DEPTH). It is conservative and does not consider a same-cycle pop.
- rd==0 suppression:
  - ALU results and load returns with rd==0 are accepted but never written (rf_we stays 0).
  - Load issues with rd==0 never set the scoreboard.
- Scoreboard: one bit per register.
  - ld_issue_valid sets bit[ld_issue_rd].
  - ld_ret_valid clears bit[ld_ret_rd].
  - Same rd issued and returned in the same cycle: the bit ends set.
- Errors (err sets and holds until reset):
  - ld_ret_valid with the scoreboard bit clear.
  - ALU handshake whose rd has the scoreboard bit set (WAW; upstream must prevent this).
  - FIFO push while full.
- Bypass, per port p, newest first:
  - FIFO tail → FIFO head → output register (rf_we & rf_wa==dec_ra[p]).
  - The first match drives dec_byp_valid=1 and the corresponding dec_byp_data.
  - dec_ra[p]==0 gives busy=0, byp_valid=0.
- dec_busy[p] = scoreboard bit[dec_ra[p]] & ~dec_byp_valid[p]. Current-cycle inputs are not bypassed.
- Reset mid-operation: FIFO contents, scoreboard and output register are discarded; the next-cycle rf_we=0 is guaranteed.

Decomposition:
- Shared package orv32_wb_pkg:
  - regaddr_t (logic [DEPTHMSB:0])
  - wb_entry_t struct {rd, data}
  - REG_ZERO constant
- Sub-module wb_skid_fifo:
  - parameterised FIFO_DEPTH, synchronous reset.
  - Exposes push/pop/full/empty/count and entry views for bypass compare.

Test Plan:
- Single ALU: alu_valid=1, rd=5, data=0x1234 at cycle 0 with idle loads → rf_we=1, rf_wa=5, rf_wd=0x1234 at cycle 1; dec_ra=5 in cycle 1 gives byp_valid=1, data=0x1234.
- Conflict: ALU rd=3 data=0xA and ld_ret rd=7 data=0xB in the same cycle (7 pending) → cycle 1 writes x7=0xB; cycle 2 writes x3=0xA; FIFO empty after cycle 2.
- Backpressure: ld_ret_valid held 4 cycles with ALU streaming → alu_ready drops after 2 accepts; no writes lost; ALU results drain in order after the loads.
- Scoreboard: issue load rd=9; dec_ra=9 → dec_busy=1 until the return cycle+1 (byp_valid=1, data=ld value); busy=0 afterwards.
- x0: ALU rd=0 data=0xFFFF → rf_we stays 0; dec_ra=0 → busy=0, byp_valid=0.
- Errors/reset: ld_ret rd=4 not pending → err=1, held; assert rst mid-drain → next cycle rf_we=0, err=0, alu_ready=0 during reset.
